vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADDR_WIDTH, 13, framebuffer word address width.
- DATA_WIDTH, 9, pixel word width (3R/3G/3B).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- i_Clk, in, 1, sole clock; all logic on rising edge.
- i_Reset, in, 1, synchronous active-high reset.
- i_Scan_En, in, 1, scanout requests a RAM read this cycle.
- i_Scan_Addr, in, ADDR_WIDTH, scanout read address.
- o_Scan_Data, out, DATA_WIDTH, scanout pixel.
- o_Scan_Valid, out, 1, o_Scan_Data valid.
- i_Wr_Valid, in, 1, host write offered.
- i_Wr_Addr, in, ADDR_WIDTH, host write address.
- i_Wr_Data, in, DATA_WIDTH, host write data.
- o_Wr_Ready, out, 1, host write accepted when high with i_Wr_Valid.
- i_Rd_Valid, in, 1, host read offered.
- i_Rd_Addr, in, ADDR_WIDTH, host read address.
- o_Rd_Ready, out, 1, host read accepted when high with i_Rd_Valid.
- o_Rd_Data, out, DATA_WIDTH, host read result.
- o_Rd_Data_Valid, out, 1, one-cycle pulse marking o_Rd_Data.
- o_Ram_Addr, out, ADDR_WIDTH, registered RAM address.
- o_Ram_Wr_En, out, 1, registered RAM write strobe.
- o_Ram_Wr_Data, out, DATA_WIDTH, registered RAM write data.
- i_Ram_Rd_Data, in, DATA_WIDTH, RAM read data; one cycle after o_Ram_Addr.

Function
REQ-003 The RAM SHALL receive exactly one access per cycle. Grant priority: scan first, then host write/read by round-robin.
REQ-004 When i_Scan_En is sampled high at edge N:
- o_Ram_Addr SHALL equal i_Scan_Addr after edge N, with o_Ram_Wr_En=0.
- o_Scan_Data SHALL take i_Ram_Rd_Data at edge N+2, with o_Scan_Valid=1 for that cycle.
- Fixed latency: 2 cycles, matching the VGA controller's lead of 2.
REQ-005 o_Scan_Valid SHALL be 0 two cycles after any cycle with i_Scan_En low. o_Scan_Data SHALL hold its last value while o_Scan_Valid is 0.
REQ-006 Host access SHALL be granted only in cycles with i_Scan_En low. Continuous scan starves host access indefinitely; no timeout.
REQ-007 A write handshake (i_Wr_Valid && o_Wr_Ready) SHALL enqueue {addr, data}. A granted write SHALL drive o_Ram_Wr_En=1 with that addr/data for exactly one cycle.
REQ-008 Writes SHALL reach RAM in acceptance order.
REQ-009 A read handshake SHALL register i_Rd_Addr as the single pending read. o_Rd_Ready SHALL be high only when all of the following hold:
- no read is pending;
- the write buffer is empty;
- no write handshake occurs in the same cycle.
REQ-010 For a read granted at edge G, o_Rd_Data SHALL capture i_Ram_Rd_Data at edge G+2, with o_Rd_Data_Valid=1 for that one cycle. The pending flag SHALL clear at that same edge.
REQ-011 Round-robin rule:
- When both a buffered write and a pending read contend in a scan-idle cycle, the requester not granted most recently SHALL win.
- The last-grant pointer SHALL initialise to "read", so the first contention goes to the write.
- An uncontested requester SHALL be granted immediately.
REQ-012 In cycles with no grant, o_Ram_Wr_En SHALL be 0 and o_Ram_Addr SHALL hold its value.
REQ-013 Read-data routing (scan, host, or none) SHALL be tracked by a 2-stage tag pipeline. Returned data SHALL never go to the wrong consumer.

Reset
REQ-014 On i_Reset high at an edge:
- write buffer SHALL be emptied;
- pending read SHALL be cleared;
- tag pipeline SHALL be cleared;
- round-robin pointer SHALL be set to "read".
REQ-015 Output values after reset:
- o_Scan_Valid=0, o_Rd_Data_Valid=0, o_Ram_Wr_En=0;
- o_Scan_Data=0, o_Rd_Data=0, o_Ram_Addr=0, o_Ram_Wr_Data=0;
- o_Wr_Ready=1, o_Rd_Ready=1.
REQ-016 Reset asserted mid-operation SHALL discard in-flight reads and buffered writes without a RAM write. Reset SHALL override all requests in the same cycle.

Configuration
REQ-017 With FB_WRITE_FIFO_EN defined:
- the write buffer SHALL be a 4-entry FIFO;
- o_Wr_Ready SHALL be low only when it holds 4 entries;
- accept and grant in the same cycle at full SHALL NOT be allowed.
REQ-018 Without FB_WRITE_FIFO_EN:
- the write buffer SHALL be a single entry;
- o_Wr_Ready SHALL be low while it is occupied;
- all other behaviour is unchanged.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset, then i_Scan_En=1 with addr 0x005 at edge 10 and RAM returning 0x1AB -> o_Scan_Data=0x1AB, o_Scan_Valid=1 in the cycle after edge 12.
- Write {0x010, 0x07F} while i_Scan_En=1 for 20 cycles -> no o_Ram_Wr_En during scan; write occurs on the first scan-idle cycle.
- FIFO_EN: 5 back-to-back writes with scan high -> o_Wr_Ready falls after the 4th; all 5 reach RAM in order once scan drops.
- Write 0x0AA to addr 3, then read addr 3 -> o_Rd_Ready low until the write is granted; o_Rd_Data=0x0AA with a one-cycle valid pulse.
- Pending read plus continuous writes with scan idle -> grants alternate write, read, write.
- Reset asserted one cycle after a read grant -> no o_Rd_Data_Valid; all outputs at REQ-015 values.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_arbiter
// Description : Single-port framebuffer RAM arbiter. VGA scanout always wins
//               the RAM. A buffered host write and a single pending host read
//               share the scan-idle cycles by round-robin. Read data is routed
//               back to its consumer through a 2-stage tag pipeline, which
//               gives a fixed 2-cycle latency.
//               Optional macro FB_WRITE_FIFO_EN: 4-entry write FIFO instead
//               of a single-entry write buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 9
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    // Scanout port
    input  logic                  i_Scan_En,
    input  logic [ADDR_WIDTH-1:0] i_Scan_Addr,
    output logic [DATA_WIDTH-1:0] o_Scan_Data,
    output logic                  o_Scan_Valid,
    // Host write port
    input  logic                  i_Wr_Valid,
    input  logic [ADDR_WIDTH-1:0] i_Wr_Addr,
    input  logic [DATA_WIDTH-1:0] i_Wr_Data,
    output logic                  o_Wr_Ready,
    // Host read port
    input  logic                  i_Rd_Valid,
    input  logic [ADDR_WIDTH-1:0] i_Rd_Addr,
    output logic                  o_Rd_Ready,
    output logic [DATA_WIDTH-1:0] o_Rd_Data,
    output logic                  o_Rd_Data_Valid,
    // RAM port
    output logic [ADDR_WIDTH-1:0] o_Ram_Addr,
    output logic                  o_Ram_Wr_En,
    output logic [DATA_WIDTH-1:0] o_Ram_Wr_Data,
    input  logic [DATA_WIDTH-1:0] i_Ram_Rd_Data
);

`ifdef FB_WRITE_FIFO_EN
    localparam int c_WB_DEPTH = 4;
`else
    localparam int c_WB_DEPTH = 1;
`endif
    localparam int c_PTR_W = (c_WB_DEPTH > 1) ? $clog2(c_WB_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(c_WB_DEPTH + 1);

    // Who owns the RAM in a given cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_SCAN = 2'd1,
        GNT_WR   = 2'd2,
        GNT_RD   = 2'd3
    } gnt_t;

    // Consumer of the read data travelling through the RAM pipeline
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_SCAN = 2'd1,
        TAG_HOST = 2'd2
    } tag_t;

    // Write buffer storage and bookkeeping
    logic [ADDR_WIDTH-1:0] r_Wb_Addr [c_WB_DEPTH];
    logic [DATA_WIDTH-1:0] r_Wb_Data [c_WB_DEPTH];
    logic [c_PTR_W-1:0]    r_Wb_Head;
    logic [c_PTR_W-1:0]    r_Wb_Tail;
    logic [c_CNT_W-1:0]    r_Wb_Count;

    // Single pending host read; Issued marks it as already sent to the RAM
    logic                  r_Rd_Pending;
    logic                  r_Rd_Issued;
    logic [ADDR_WIDTH-1:0] r_Rd_Addr;

    // Round-robin pointer: 1 = host read was granted most recently
    logic                  r_Last_Rd;

    tag_t                  r_Tag1;
    tag_t                  r_Tag2;

    logic                  w_Wb_Empty;
    logic                  w_Wb_Full;
    logic                  w_Wr_Push;
    logic                  w_Wr_Pop;
    logic                  w_Rd_Push;
    logic                  w_Wr_Req;
    logic                  w_Rd_Req;
    gnt_t                  w_Gnt;

    function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] p);
        if (p == c_PTR_W'(c_WB_DEPTH - 1)) begin
            return '0;
        end
        return p + c_PTR_W'(1);
    endfunction

    assign w_Wb_Empty = (r_Wb_Count == '0);
    assign w_Wb_Full  = (r_Wb_Count == c_CNT_W'(c_WB_DEPTH));

    // Ready is purely occupancy based, so a full buffer never accepts even
    // when its head is being granted in the same cycle.
    assign o_Wr_Ready = !w_Wb_Full;
    assign w_Wr_Push  = i_Wr_Valid && o_Wr_Ready;

    // A read is only accepted once every earlier write has reached the RAM,
    // so it can never overtake buffered data at the same address.
    assign o_Rd_Ready = !r_Rd_Pending && w_Wb_Empty && !w_Wr_Push;
    assign w_Rd_Push  = i_Rd_Valid && o_Rd_Ready;

    assign w_Wr_Req   = !w_Wb_Empty;
    assign w_Rd_Req   = r_Rd_Pending && !r_Rd_Issued;
    assign w_Wr_Pop   = (w_Gnt == GNT_WR);

    // Grant selection: scan first, then round-robin between write and read
    always_comb begin
        w_Gnt = GNT_NONE;
        if (i_Scan_En) begin
            w_Gnt = GNT_SCAN;
        end else if (w_Wr_Req && w_Rd_Req) begin
            w_Gnt = r_Last_Rd ? GNT_WR : GNT_RD;
        end else if (w_Wr_Req) begin
            w_Gnt = GNT_WR;
        end else if (w_Rd_Req) begin
            w_Gnt = GNT_RD;
        end
    end

    // Write buffer payload storage (no reset needed, qualified by count)
    always_ff @(posedge i_Clk) begin
        if (w_Wr_Push) begin
            r_Wb_Addr[r_Wb_Tail] <= i_Wr_Addr;
            r_Wb_Data[r_Wb_Tail] <= i_Wr_Data;
        end
    end

    // Write buffer pointers and occupancy
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Wb_Head  <= '0;
            r_Wb_Tail  <= '0;
            r_Wb_Count <= '0;
        end else begin
            if (w_Wr_Push) begin
                r_Wb_Tail <= f_next_ptr(r_Wb_Tail);
            end
            if (w_Wr_Pop) begin
                r_Wb_Head <= f_next_ptr(r_Wb_Head);
            end
            if (w_Wr_Push && !w_Wr_Pop) begin
                r_Wb_Count <= r_Wb_Count + c_CNT_W'(1);
            end else if (!w_Wr_Push && w_Wr_Pop) begin
                r_Wb_Count <= r_Wb_Count - c_CNT_W'(1);
            end
        end
    end

    // Pending host read: set on handshake, retired when its data returns
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Rd_Pending <= 1'b0;
            r_Rd_Issued  <= 1'b0;
            r_Rd_Addr    <= '0;
        end else begin
            if (w_Rd_Push) begin
                r_Rd_Pending <= 1'b1;
                r_Rd_Issued  <= 1'b0;
                r_Rd_Addr    <= i_Rd_Addr;
            end
            if (w_Gnt == GNT_RD) begin
                r_Rd_Issued <= 1'b1;
            end
            if (r_Tag2 == TAG_HOST) begin
                r_Rd_Pending <= 1'b0;
                r_Rd_Issued  <= 1'b0;
            end
        end
    end

    // Registered RAM command; address holds when nobody is granted
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Ram_Addr    <= '0;
            o_Ram_Wr_En   <= 1'b0;
            o_Ram_Wr_Data <= '0;
        end else begin
            o_Ram_Wr_En <= 1'b0;
            case (w_Gnt)
                GNT_SCAN: o_Ram_Addr <= i_Scan_Addr;
                GNT_WR: begin
                    o_Ram_Addr    <= r_Wb_Addr[r_Wb_Head];
                    o_Ram_Wr_Data <= r_Wb_Data[r_Wb_Head];
                    o_Ram_Wr_En   <= 1'b1;
                end
                GNT_RD:   o_Ram_Addr <= r_Rd_Addr;
                default:  ;
            endcase
        end
    end

    // Tag pipeline and round-robin pointer
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Tag1    <= TAG_NONE;
            r_Tag2    <= TAG_NONE;
            r_Last_Rd <= 1'b1;
        end else begin
            case (w_Gnt)
                GNT_SCAN: r_Tag1 <= TAG_SCAN;
                GNT_RD:   r_Tag1 <= TAG_HOST;
                default:  r_Tag1 <= TAG_NONE;
            endcase
            r_Tag2 <= r_Tag1;
            if (w_Gnt == GNT_WR) begin
                r_Last_Rd <= 1'b0;
            end else if (w_Gnt == GNT_RD) begin
                r_Last_Rd <= 1'b1;
            end
        end
    end

    // Return-data capture, steered by the tag leaving the pipeline
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Scan_Data     <= '0;
            o_Scan_Valid    <= 1'b0;
            o_Rd_Data       <= '0;
            o_Rd_Data_Valid <= 1'b0;
        end else begin
            o_Scan_Valid    <= (r_Tag2 == TAG_SCAN);
            o_Rd_Data_Valid <= (r_Tag2 == TAG_HOST);
            if (r_Tag2 == TAG_SCAN) begin
                o_Scan_Data <= i_Ram_Rd_Data;
            end
            if (r_Tag2 == TAG_HOST) begin
                o_Rd_Data <= i_Ram_Rd_Data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_fb_arbiter
// Description : Scoreboard bench for vga_fb_arbiter with a synchronous RAM
//               model. Honours FB_WRITE_FIFO_EN for the write buffer depth.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fb_arbiter;

`ifdef FB_WRITE_FIFO_EN
    localparam int c_DEPTH = 4;
`else
    localparam int c_DEPTH = 1;
`endif

    logic        i_Clk = 1'b0;
    logic        i_Reset;
    logic        i_Scan_En;
    logic [12:0] i_Scan_Addr;
    logic [8:0]  o_Scan_Data;
    logic        o_Scan_Valid;
    logic        i_Wr_Valid;
    logic [12:0] i_Wr_Addr;
    logic [8:0]  i_Wr_Data;
    logic        o_Wr_Ready;
    logic        i_Rd_Valid;
    logic [12:0] i_Rd_Addr;
    logic        o_Rd_Ready;
    logic [8:0]  o_Rd_Data;
    logic        o_Rd_Data_Valid;
    logic [12:0] o_Ram_Addr;
    logic        o_Ram_Wr_En;
    logic [8:0]  o_Ram_Wr_Data;
    logic [8:0]  i_Ram_Rd_Data;

    logic [8:0]  mem    [0:8191];
    logic [8:0]  shadow [0:8191];

    logic [8:0]  scan_q [$];
    logic [8:0]  rd_q   [$];
    logic [21:0] wr_q   [$];

    int n_tests = 0;
    int n_fail  = 0;

    vga_fb_arbiter #(.ADDR_WIDTH(13), .DATA_WIDTH(9)) dut (
        .i_Clk           (i_Clk),
        .i_Reset         (i_Reset),
        .i_Scan_En       (i_Scan_En),
        .i_Scan_Addr     (i_Scan_Addr),
        .o_Scan_Data     (o_Scan_Data),
        .o_Scan_Valid    (o_Scan_Valid),
        .i_Wr_Valid      (i_Wr_Valid),
        .i_Wr_Addr       (i_Wr_Addr),
        .i_Wr_Data       (i_Wr_Data),
        .o_Wr_Ready      (o_Wr_Ready),
        .i_Rd_Valid      (i_Rd_Valid),
        .i_Rd_Addr       (i_Rd_Addr),
        .o_Rd_Ready      (o_Rd_Ready),
        .o_Rd_Data       (o_Rd_Data),
        .o_Rd_Data_Valid (o_Rd_Data_Valid),
        .o_Ram_Addr      (o_Ram_Addr),
        .o_Ram_Wr_En     (o_Ram_Wr_En),
        .o_Ram_Wr_Data   (o_Ram_Wr_Data),
        .i_Ram_Rd_Data   (i_Ram_Rd_Data)
    );

    always #5 i_Clk = ~i_Clk;

    function automatic logic [8:0] f_init(input int a);
        if (a == 5) return 9'h1AB;
        return 9'((a * 37 + 11) & 32'h1FF);
    endfunction

    // Synchronous single-port RAM: data one cycle after the address
    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = f_init(i);
        i_Ram_Rd_Data = '0;
        forever begin
            @(posedge i_Clk);
            if (o_Ram_Wr_En) mem[o_Ram_Addr] <= o_Ram_Wr_Data;
            i_Ram_Rd_Data <= mem[o_Ram_Addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every DUT output event must match the head of its queue
    always @(negedge i_Clk) begin
        logic [8:0]  e9;
        logic [21:0] e22;
        if (o_Scan_Valid) begin
            if (scan_q.size() == 0) check("scan_unexpected", 1, 0);
            else begin
                e9 = scan_q.pop_front();
                check("scan_data", 32'(o_Scan_Data), 32'(e9));
            end
        end
        if (o_Rd_Data_Valid) begin
            if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
            else begin
                e9 = rd_q.pop_front();
                check("rd_data", 32'(o_Rd_Data), 32'(e9));
            end
        end
        if (o_Ram_Wr_En) begin
            if (wr_q.size() == 0) check("ram_wr_unexpected", 1, 0);
            else begin
                e22 = wr_q.pop_front();
                check("ram_wr", 32'({o_Ram_Addr, o_Ram_Wr_Data}), 32'(e22));
            end
        end
    end

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic scan_burst(input logic [12:0] base, input int n, input bit chk_no_wr);
        for (int i = 0; i < n; i++) begin
            i_Scan_En   = 1'b1;
            i_Scan_Addr = base + 13'(i);
            scan_q.push_back(shadow[base + 13'(i)]);
            tick();
            if (chk_no_wr) check("no_wr_during_scan", 32'(o_Ram_Wr_En), 0);
        end
        i_Scan_En = 1'b0;
    endtask

    task automatic do_write(input logic [12:0] a, input logic [8:0] d);
        bit rdy;
        int k;
        rdy = 1'b0;
        i_Wr_Valid = 1'b1;
        i_Wr_Addr  = a;
        i_Wr_Data  = d;
        for (k = 0; k < 200; k++) begin
            @(negedge i_Clk);
            rdy = o_Wr_Ready;
            tick();
            if (rdy) break;
        end
        i_Wr_Valid = 1'b0;
        if (!rdy) check("wr_accept_timeout", 0, 1);
        else begin
            shadow[a] = d;
            wr_q.push_back({a, d});
        end
    endtask

    task automatic do_read(input logic [12:0] a, input bit exp_push);
        bit rdy;
        int k;
        rdy = 1'b0;
        i_Rd_Valid = 1'b1;
        i_Rd_Addr  = a;
        for (k = 0; k < 200; k++) begin
            @(negedge i_Clk);
            rdy = o_Rd_Ready;
            tick();
            if (rdy) break;
        end
        i_Rd_Valid = 1'b0;
        if (!rdy) check("rd_accept_timeout", 0, 1);
        else if (exp_push) rd_q.push_back(shadow[a]);
    endtask

    task automatic do_reset();
        i_Reset = 1'b1;
        tick();
        tick();
        i_Reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) shadow[i] = f_init(i);
        i_Reset = 1'b1; i_Scan_En = 1'b0; i_Scan_Addr = '0;
        i_Wr_Valid = 1'b0; i_Wr_Addr = '0; i_Wr_Data = '0;
        i_Rd_Valid = 1'b0; i_Rd_Addr = '0;

        // Reset state after edge 3, then scan addr 0x005 sampled at edge 10
        repeat (3) tick();
        i_Reset = 1'b0;
        check("rst_scan_valid", 32'(o_Scan_Valid), 0);
        check("rst_rd_valid",   32'(o_Rd_Data_Valid), 0);
        check("rst_ram_wr_en",  32'(o_Ram_Wr_En), 0);
        check("rst_ram_addr",   32'(o_Ram_Addr), 0);
        check("rst_wr_ready",   32'(o_Wr_Ready), 1);
        check("rst_rd_ready",   32'(o_Rd_Ready), 1);
        repeat (6) tick();
        scan_burst(13'h005, 1, 1'b0);
        check("scan_ram_addr", 32'(o_Ram_Addr), 32'h005);
        tick();
        check("scan_valid_e11", 32'(o_Scan_Valid), 0);
        tick();
        check("scan_valid_e12", 32'(o_Scan_Valid), 1);
        check("scan_data_e12",  32'(o_Scan_Data), 32'h1AB);
        tick();
        check("scan_valid_e13", 32'(o_Scan_Valid), 0);
        check("scan_data_hold", 32'(o_Scan_Data), 32'h1AB);

        // Write held off by 20 cycles of scan, lands on first idle cycle
        fork
            scan_burst(13'h300, 20, 1'b1);
            do_write(13'h010, 9'h07F);
        join
        tick();
        check("wr_after_scan_en",   32'(o_Ram_Wr_En), 1);
        check("wr_after_scan_addr", 32'(o_Ram_Addr), 32'h010);
        check("wr_after_scan_data", 32'(o_Ram_Wr_Data), 32'h07F);
        repeat (4) tick();

        // Five back-to-back writes under scan: buffer fills, then drains in order
        fork
            scan_burst(13'h400, 20, 1'b0);
            for (int i = 0; i < 5; i++) begin
                do_write(13'h040 + 13'(i), 9'h100 + 9'(i));
                if (i < c_DEPTH) check("wr_ready_fill", 32'(o_Wr_Ready), 32'(i + 1 < c_DEPTH));
            end
        join
        repeat (8) tick();

        // Write then read of the same address
        do_write(13'h003, 9'h0AA);
        check("rd_ready_blocked", 32'(o_Rd_Ready), 0);
        do_read(13'h003, 1'b1);
        begin
            int k;
            for (k = 0; k < 20; k++) begin
                @(negedge i_Clk);
                if (o_Rd_Data_Valid) break;
            end
            check("rd_valid_seen", 32'(k < 20), 1);
            @(negedge i_Clk);
            check("rd_valid_pulse", 32'(o_Rd_Data_Valid), 0);
            check("rd_data_hold",   32'(o_Rd_Data), 32'h0AA);
        end
        repeat (4) tick();

        // Contention: pending read vs buffered writes -> W, R, W
        do_reset();
        fork
            scan_burst(13'h200, 8, 1'b0);
            begin
                do_read(13'd20, 1'b1);
                do_write(13'h050, 9'h011);
                do_write(13'h051, 9'h022);
                do_write(13'h052, 9'h033);
            end
            begin
                repeat (9) @(posedge i_Clk);
                #1;
                check("rr_g0_wr",   32'(o_Ram_Wr_En), 1);
                check("rr_g0_addr", 32'(o_Ram_Addr), 32'h050);
                tick();
                check("rr_g1_rd",   32'(o_Ram_Wr_En), 0);
                check("rr_g1_addr", 32'(o_Ram_Addr), 32'd20);
                tick();
                check("rr_g2_wr",   32'(o_Ram_Wr_En), 1);
                check("rr_g2_addr", 32'(o_Ram_Addr), 32'h051);
            end
        join
        repeat (10) tick();

        // Reset one cycle after a read grant discards the read
        do_read(13'd30, 1'b0);
        tick();
        check("rst_rd_granted", 32'(o_Ram_Addr), 32'd30);
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        check("mid_rst_scan_valid", 32'(o_Scan_Valid), 0);
        check("mid_rst_rd_valid",   32'(o_Rd_Data_Valid), 0);
        check("mid_rst_wr_en",      32'(o_Ram_Wr_En), 0);
        check("mid_rst_scan_data",  32'(o_Scan_Data), 0);
        check("mid_rst_rd_data",    32'(o_Rd_Data), 0);
        check("mid_rst_ram_addr",   32'(o_Ram_Addr), 0);
        check("mid_rst_wr_data",    32'(o_Ram_Wr_Data), 0);
        check("mid_rst_wr_ready",   32'(o_Wr_Ready), 1);
        check("mid_rst_rd_ready",   32'(o_Rd_Ready), 1);
        repeat (4) begin
            @(negedge i_Clk);
            check("mid_rst_no_rd_valid", 32'(o_Rd_Data_Valid), 0);
        end

        repeat (5) tick();
        check("scan_q_empty", 32'(scan_q.size()), 0);
        check("rd_q_empty",   32'(rd_q.size()), 0);
        check("wr_q_empty",   32'(wr_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
